lane_traffic_generator_mk2: RTL and testbench
=============================================

# lane_traffic_generator_mk2

Sequential obstacle source for the auto-change-lanes datapath. It produces the four 4-bit lane occupancy vectors that the downstream lane-occupancy detector and lane-change logic consume. On every scroll step, each lane's cars advance one position toward the player, and at most one new car spawns at the far end, chosen by an 8-bit LFSR. It also keeps a saturating count of cars that have passed the player.

## Interface
Parameters:
- TICK_DIV, default 25_000_000: clock cycles per scroll step. Legal range is 1 to 2^32-1.
- SEED, default 8'hA5: LFSR reset/clear value. A value of 0 is replaced by 8'h01.

Ports:
- clk, input, 1: system clock. All state changes on its rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- enable, input, 1: when high, the tick counter runs. When low, all state holds.
- clear, input, 1: synchronous restart. Takes priority over enable.
- lane0, lane1, lane2, lane3, output, 4 each: lane occupancy. Bit 3 is the farthest position, bit 0 is adjacent to the player. All are registered.
- step, output, 1: one-cycle pulse, high in the cycle in which the lanes have just updated. Registered.
- passed, output, 8: count of cars that shifted out of bit 0. Saturates at 255. Registered.

## Operation
- State:
  - 32-bit tick counter `cnt`
  - 8-bit LFSR `lfsr`
  - four lane registers
  - `passed`
  - `step`
- Reset (resetn low, asynchronous):
  - cnt = 0
  - lfsr = SEED, or 8'h01 if SEED is 0
  - all lanes = 4'b0000
  - passed = 0
  - step = 0
- Priority each edge: clear, then enable, then hold.
  - clear = 1 loads the reset values synchronously, including step = 0.
- enable = 0: everything holds, and step = 0.
- enable = 1 and cnt != TICK_DIV-1: cnt increments, and step = 0.
- enable = 1 and cnt == TICK_DIV-1 (scroll edge):
  - cnt resets to 0.
  - step is set to 1.
  - Spawn decision uses the current lfsr value:
    - spawn = lfsr[2]
    - target lane = lfsr[1:0]
  - Each lane k is updated to {new_k, lane_k[3:1]}, where new_k = spawn && (lfsr[1:0] == k).
  - `passed` is increased by the count of bits lane0[0] through lane3[0] as they were before the shift (0 to 4). The sum saturates at 255 and never wraps.
  - lfsr advances once using Galois right shift with taps 8'hB8: next = (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00).
- At most one car is inserted per step, so the far column never fills all four lanes in one step.
- The LFSR advances only on scroll edges. The traffic sequence is therefore deterministic per SEED and independent of pauses in enable.

## Timing
- Scroll edges occur every TICK_DIV enabled cycles. The first one is at the TICK_DIV-th enabled rising edge after reset release or clear.
- Lanes, passed, lfsr and step all update on the same scroll edge, so step is high exactly while the new lane values are first visible.
- TICK_DIV = 1: every enabled edge is a scroll edge, and step stays high continuously while enabled.
- Dropping enable in the middle of a count freezes cnt. Counting resumes from the same value with no lost or extra step.
- clear on a would-be scroll edge: clear wins. No shift occurs and step = 0.
- resetn asserted at any time forces all outputs to their reset values immediately, without waiting for clk.

## Test plan
- Reset: drive resetn low mid-count with non-zero lanes.
  - Required: all lanes = 0, passed = 0 and step = 0 immediately (asynchronously).
  - After release with TICK_DIV=4, first step pulse on the 4th enabled edge.
- Spawn sequence, SEED=8'hA5, TICK_DIV=4:
  - Steps 1 to 5 use lfsr values A5, EA, 75, 82, 41.
  - Required lane1 after each step: 1000, 0100, 1010, 0101, 0010.
  - Other lanes stay 0.
  - passed = 1 after step 5.
- Enable gating: deassert enable for 10 cycles when cnt = 2.
  - Required: no step pulse and outputs frozen during the pause.
  - Next step arrives exactly 2 enabled cycles after re-enable.
- Clear priority: assert clear on a scroll edge after 3 steps.
  - Required: lanes = 0, passed = 0 and step = 0.
  - The following sequence repeats A5, EA, ... exactly.
- Saturation and single spawn: TICK_DIV=1, run 2000 steps.
  - Required: passed reaches 255 and holds.
  - Each step changes at most one lane's bit 3 from the shift-in.
  - step stays high continuously.
- SEED=0: run 20 steps.
  - Required: lfsr starts at 8'h01, never becomes 0, and at least one spawn occurs.

Source files
------------

// File: rtl/lane_traffic_generator_mk2.sv
// Scrolling four-lane obstacle source: cars shift toward the player every
// TICK_DIV enabled cycles, one optional spawn per step chosen by an 8-bit LFSR.
module lane_traffic_generator_mk2 #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] lane0,
  output logic [3:0] lane1,
  output logic [3:0] lane2,
  output logic [3:0] lane3,
  output logic       step,
  output logic [7:0] passed
);

  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [31:0] CNT_LAST = 32'(TICK_DIV - 1);

  logic [31:0] cnt;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic [3:0]  spawn_onehot;
  logic [2:0]  exits;
  logic [8:0]  passed_sum;
  logic [7:0]  passed_next;

  always_comb begin
    spawn_onehot = '0;
    if (lfsr[2]) spawn_onehot = 4'b0001 << lfsr[1:0];
    lfsr_next   = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    exits       = {2'b00, lane0[0]} + {2'b00, lane1[0]}
                + {2'b00, lane2[0]} + {2'b00, lane3[0]};
    // Nine-bit sum so the carry marks saturation instead of wrapping.
    passed_sum  = {1'b0, passed} + {6'b000000, exits};
    passed_next = passed_sum[8] ? 8'hFF : passed_sum[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      lfsr   <= SEED_EFF;
      lane0  <= '0;
      lane1  <= '0;
      lane2  <= '0;
      lane3  <= '0;
      passed <= '0;
      step   <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      lfsr   <= SEED_EFF;
      lane0  <= '0;
      lane1  <= '0;
      lane2  <= '0;
      lane3  <= '0;
      passed <= '0;
      step   <= 1'b0;
    end else if (!enable) begin
      step <= 1'b0;
    end else if (cnt != CNT_LAST) begin
      cnt  <= cnt + 32'd1;
      step <= 1'b0;
    end else begin
      cnt    <= '0;
      step   <= 1'b1;
      lane0  <= {spawn_onehot[0], lane0[3:1]};
      lane1  <= {spawn_onehot[1], lane1[3:1]};
      lane2  <= {spawn_onehot[2], lane2[3:1]};
      lane3  <= {spawn_onehot[3], lane3[3:1]};
      passed <= passed_next;
      lfsr   <= lfsr_next;
    end
  end

endmodule

// File: tb/tb_lane_traffic_generator_mk2.sv
// Bench for lane_traffic_generator_mk2: three parameterisations share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_lane_traffic_generator_mk2;

  logic clk;
  logic resetn;
  logic enable;
  logic clear;

  logic [3:0] lanes [3][4];
  logic       stp [3];
  logic [7:0] psd [3];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]      cnt;
    logic [7:0]       lfsr;
    logic [3:0][3:0]  ln;
    logic [7:0]       passed;
    logic             step;
  } mstate_t;

  typedef struct {
    int unsigned cycles;
    logic [3:0]  lane1;
    logic [7:0]  passed;
  } vec_t;

  int unsigned td [3];
  logic [7:0]  sd [3];
  mstate_t     m  [3];
  vec_t        tbl [5];

  lane_traffic_generator_mk2 #(.TICK_DIV(4), .SEED(8'hA5)) dut_a (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .lane0(lanes[0][0]), .lane1(lanes[0][1]), .lane2(lanes[0][2]), .lane3(lanes[0][3]),
    .step(stp[0]), .passed(psd[0]));

  lane_traffic_generator_mk2 #(.TICK_DIV(1), .SEED(8'hA5)) dut_b (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .lane0(lanes[1][0]), .lane1(lanes[1][1]), .lane2(lanes[1][2]), .lane3(lanes[1][3]),
    .step(stp[1]), .passed(psd[1]));

  lane_traffic_generator_mk2 #(.TICK_DIV(3), .SEED(8'h00)) dut_c (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .lane0(lanes[2][0]), .lane1(lanes[2][1]), .lane2(lanes[2][2]), .lane3(lanes[2][3]),
    .step(stp[2]), .passed(psd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mstate_t mreset(input logic [7:0] seed);
    mstate_t s;
    s = '0;
    s.lfsr = (seed == 8'h00) ? 8'h01 : seed;
    return s;
  endfunction

  // Reference behaviour written from the scroll rules with plain arithmetic.
  function automatic mstate_t mnext(input mstate_t s, input logic en, input logic clr,
                                    input int unsigned tdiv, input logic [7:0] seed);
    mstate_t n;
    int tgt;
    int spawn;
    int out;
    int sum;
    n = s;
    if (clr) return mreset(seed);
    n.step = 1'b0;
    if (!en) return n;
    if (s.cnt != 32'(tdiv - 1)) begin
      n.cnt = s.cnt + 1;
      return n;
    end
    n.cnt  = 0;
    n.step = 1'b1;
    tgt    = int'(s.lfsr % 4);
    spawn  = int'((s.lfsr / 4) % 2);
    out    = 0;
    for (int k = 0; k < 4; k++) begin
      out += int'(s.ln[k] % 2);
      n.ln[k] = 4'(int'(s.ln[k] / 2) + ((spawn == 1 && tgt == k) ? 8 : 0));
    end
    sum      = int'(s.passed) + out;
    n.passed = (sum > 255) ? 8'd255 : 8'(sum);
    n.lfsr   = 8'(s.lfsr / 2) ^ ((s.lfsr % 2 == 1) ? 8'hB8 : 8'h00);
    return n;
  endfunction

  function automatic logic [24:0] mvec(input mstate_t s);
    return {s.ln[3], s.ln[2], s.ln[1], s.ln[0], s.passed, s.step};
  endfunction

  function automatic logic [24:0] dvec(input int d);
    return {lanes[d][3], lanes[d][2], lanes[d][1], lanes[d][0], psd[d], stp[d]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int d = 0; d < 3; d++)
      m[d] = resetn ? mnext(m[d], enable, clear, td[d], sd[d]) : mreset(sd[d]);
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("model_d%0d", d), 32'(dvec(d)), 32'(mvec(m[d])));
  endtask

  task automatic wait_step(output int unsigned n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!stp[0] && n < 20);
  endtask

  task automatic run_table(input string tag);
    int unsigned n;
    for (int i = 0; i < 5; i++) begin
      wait_step(n);
      chk($sformatf("%s_lat%0d", tag, i), n, tbl[i].cycles);
      chk($sformatf("%s_lane1_%0d", tag, i), 32'(lanes[0][1]), 32'(tbl[i].lane1));
      chk($sformatf("%s_others%0d", tag, i),
          32'({lanes[0][0], lanes[0][2], lanes[0][3]}), 32'd0);
      chk($sformatf("%s_passed%0d", tag, i), 32'(psd[0]), 32'(tbl[i].passed));
    end
  endtask

  initial begin
    int unsigned n;
    logic [24:0] snap;
    int step_low;
    int viol;
    int sp_dut;
    int sp_mod;
    int bits3;

    td[0] = 4;  td[1] = 1;  td[2] = 3;
    sd[0] = 8'hA5; sd[1] = 8'hA5; sd[2] = 8'h00;
    tbl[0] = '{4, 4'b1000, 8'd0};
    tbl[1] = '{4, 4'b0100, 8'd0};
    tbl[2] = '{4, 4'b1010, 8'd0};
    tbl[3] = '{4, 4'b0101, 8'd0};
    tbl[4] = '{4, 4'b0010, 8'd1};

    resetn = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    for (int d = 0; d < 3; d++) m[d] = mreset(sd[d]);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("reset_d%0d", d), 32'(dvec(d)), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    enable = 1'b1;
    run_table("seq");

    // Pause with cnt == 2: outputs freeze and the step lands two enabled edges later.
    cycle();
    cycle();
    snap = dvec(0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk($sformatf("pause_frozen%0d", i), 32'(dvec(0)), 32'(snap));
    end
    enable = 1'b1;
    wait_step(n);
    chk("resume_lat", n, 2);

    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) wait_step(n);
    cycle();
    cycle();
    cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clear_on_edge", 32'(dvec(0)), 32'd0);
    run_table("replay");

    // Asynchronous reset mid-count with lanes occupied.
    cycle();
    cycle();
    chk("pre_reset_nonzero", 32'(lanes[0][1] != 4'd0), 32'd1);
    #2 resetn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async_reset_d%0d", d), 32'(dvec(d)), 32'd0);
      m[d] = mreset(sd[d]);
    end
    @(negedge clk);
    resetn = 1'b1;
    wait_step(n);
    chk("post_reset_lat", n, 4);

    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) < 80);
      clear  = ($urandom_range(0, 99) < 2);
      cycle();
    end

    enable = 1'b1;
    clear  = 1'b1;
    cycle();
    clear = 1'b0;
    step_low = 0;
    viol     = 0;
    sp_dut   = 0;
    sp_mod   = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (!stp[1]) step_low++;
      bits3 = int'(lanes[1][0][3]) + int'(lanes[1][1][3]) + int'(lanes[1][2][3]) + int'(lanes[1][3][3]);
      if (bits3 > 1) viol++;
      if (i < 60 && stp[2] && (lanes[2][0][3] | lanes[2][1][3] | lanes[2][2][3] | lanes[2][3][3]))
        sp_dut++;
      if (i < 60 && m[2].step && (m[2].ln[0][3] | m[2].ln[1][3] | m[2].ln[2][3] | m[2].ln[3][3]))
        sp_mod++;
    end
    chk("sat_passed", 32'(psd[1]), 32'd255);
    chk("sat_step_low", 32'(step_low), 32'd0);
    chk("single_spawn", 32'(viol), 32'd0);
    chk("seed0_spawns", 32'(sp_dut), 32'(sp_mod));
    chk("seed0_any_spawn", 32'(sp_dut > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
